// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_e   : responder FSM encoding (IDLE / WAIT / RESP)
//   BYTE_W    : width of one byte lane
//   NUM_LANES : byte lanes per word
//   WORD_W    : data word width
//   addr_err  : flags a misaligned or out-of-range byte address
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int BYTE_W    = 8;
  localparam int NUM_LANES = 4;
  localparam int WORD_W    = BYTE_W * NUM_LANES;

  // aw is the word-address width; any byte-address bit above the array
  // range, or a non-word-aligned address, is an error.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// read port. The read is read-first: on a write cycle rdata captures the
// word as it was before the write.
// Ports:
//   clk   : clock, rising edge
//   en    : access enable (read always, write when we)
//   we    : write enable
//   be    : byte-lane write enables
//   addr  : word address
//   wdata : write data, lane aligned
//   rdata : registered read data, updated only on enabled cycles
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [NUM_LANES-1:0]  be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem_q [2**ADDR_WIDTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (be[i]) begin
            mem_q[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
          end
        end
      end
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: target side of the core's MEM-stage load/store
// interface. One request at a time over valid/ready, a configurable wait,
// then a word read or byte-strobed write, reported on a valid/ready
// response channel.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   req_valid : request present           req_ready : can accept a request
//   req_we    : 1 = store, 0 = load        req_addr  : byte address
//   req_wdata : store data, lane aligned   req_be    : byte enables
//   rsp_valid : response present           rsp_ready : core accepts response
//   rsp_rdata : load data (0 for stores and errors)
//   rsp_err   : misaligned or out-of-range access
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [31:0]          req_addr,
  input  logic [WORD_W-1:0]    req_wdata,
  input  logic [NUM_LANES-1:0] req_be,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_W-1:0]    rsp_rdata,
  output logic                 rsp_err
);

  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rd_sel_q, rd_sel_d;
  logic                 rsp_err_q, rsp_err_d;

  logic                 we_q;
  logic [31:0]          addr_q;
  logic [WORD_W-1:0]    wdata_q;
  logic [NUM_LANES-1:0] be_q;

  logic                 accept;
  logic                 commit;
  logic                 c_we;
  logic                 c_err;
  logic [31:0]          c_addr;
  logic [WORD_W-1:0]    c_wdata;
  logic [NUM_LANES-1:0] c_be;
  logic [WORD_W-1:0]    arr_rdata;

  assign req_ready = (state_q == ST_IDLE) && rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == ST_RESP);

  // With zero latency the commit happens in the accept cycle itself, so the
  // live request fields feed the array; otherwise the latched copy does.
  always_comb begin
    if (state_q == ST_IDLE) begin
      c_we    = req_we;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_be    = req_be;
    end else begin
      c_we    = we_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
      c_be    = be_q;
    end
    c_err = addr_err(c_addr, ADDR_WIDTH);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_sel_d  = rd_sel_q;
    rsp_err_d = rsp_err_q;
    commit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d = CNT_W'(LATENCY);
          if (LATENCY == 0) begin
            commit  = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Commit one cycle early so the registered array read lands
        // exactly as the FSM enters RESP.
        if (cnt_q == CNT_W'(1)) begin
          commit  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (commit) begin
      rd_sel_d  = !c_we && !c_err;
      rsp_err_d = c_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_sel_q  <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_sel_q  <= rd_sel_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  dmem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .en   (commit && !c_err),
    .we   (c_we),
    .be   (c_be),
    .addr (c_addr[ADDR_WIDTH+1:2]),
    .wdata(c_wdata),
    .rdata(arr_rdata)
  );

  // The array read register is left unreset; rd_sel_q masks it so stores,
  // errors and reset all present zero.
  assign rsp_rdata = rd_sel_q ? arr_rdata : '0;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        z_req_valid = 1'b0;
  logic        z_req_ready;
  logic        z_req_we = 1'b0;
  logic [31:0] z_req_addr = '0;
  logic [31:0] z_req_wdata = '0;
  logic [3:0]  z_req_be = '0;
  logic        z_rsp_valid;
  logic        z_rsp_ready = 1'b1;
  logic [31:0] z_rsp_rdata;
  logic        z_rsp_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Called at a negedge. Presents a request, waits for accept, scrambles the
  // request fields, and returns at the first negedge where rsp_valid is high.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rdata,
                       output logic err, output int lat);
    int guard = 0;
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_we = ~we; req_addr = 32'hFFFF_FFFF; req_wdata = ~wdata; req_be = ~be;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
  endtask

  // Full transaction with rsp_ready high; returns at the negedge after the
  // response handshake, back in IDLE.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    issue(we, addr, wdata, be, rd, er, lat);
    chk({tag, "_lat"},   32'(lat), 32'd3);
    chk({tag, "_rdata"}, rd, exp_rdata);
    chk({tag, "_err"},   32'(er), 32'(exp_err));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          acc [$];
    int          gap;

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err",   32'(rsp_err), 32'd0);
    chk("rst_l0_ready",  32'(z_req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Store then load
    txn("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    txn("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

    // Byte-strobe merge, plus empty strobe
    txn("st20a", 1'b1, 32'h20, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
    txn("st20b", 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0);
    txn("ld20",  1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0);
    txn("st20z", 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
    txn("ld20z", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0);

    // Backpressure
    rsp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    chk("bp_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_done_valid", 32'(rsp_valid), 32'd0);
    chk("bp_done_ready", 32'(req_ready), 32'd1);

    // Errors
    txn("ld13",   1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1);
    txn("st00",   1'b1, 32'h0, 32'h0102_0304, 4'hF, 32'h0, 1'b0);
    txn("st1000", 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
    txn("ld00",   1'b0, 32'h0, 32'h0, 4'h0, 32'h0102_0304, 1'b0);

    // Reset during WAIT discards the pending store
    txn("st40", 1'b1, 32'h40, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
    req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_wait_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_wait_valid", 32'(rsp_valid), 32'd0);
    chk("rst_wait_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    txn("ld40", 1'b0, 32'h40, 32'h0, 4'h0, 32'h1234_5678, 1'b0);

    // Zero-latency instance
    z_req_we = 1'b1; z_req_addr = 32'h8; z_req_wdata = 32'h55AA_55AA; z_req_be = 4'hF;
    z_req_valid = 1'b1;
    chk("l0_idle_ready", 32'(z_req_ready), 32'd1);
    @(negedge clk);
    z_req_valid = 1'b0;
    chk("l0_st_valid", 32'(z_rsp_valid), 32'd1);
    chk("l0_st_err",   32'(z_rsp_err), 32'd0);
    @(negedge clk);
    z_req_we = 1'b0; z_req_valid = 1'b1;
    @(negedge clk);
    z_req_valid = 1'b0;
    chk("l0_ld_valid", 32'(z_rsp_valid), 32'd1);
    chk("l0_ld_rdata", z_rsp_rdata, 32'h55AA_55AA);
    @(negedge clk);
    z_req_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (z_req_ready) acc.push_back(c);
      @(negedge clk);
    end
    z_req_valid = 1'b0;
    chk("l0_accepts", 32'(acc.size()), 32'd3);
    for (int k = 1; k < acc.size(); k++) begin
      gap = acc[k] - acc[k-1];
      chk("l0_spacing", 32'(gap), 32'd2);
    end
    chk("l0_b2b_rdata", z_rsp_rdata, 32'h55AA_55AA);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
